note_sequencer: RTL and testbench

//  Step sequencer driving the synth voice: plays a programmable pattern by

---
 rtl/note_sequencer_pkg.sv | 43 ++++
 rtl/note_sequencer_if.sv | 30 +++
 rtl/note_sequencer_rom.sv | 9 +
 rtl/note_sequencer.sv | 140 ++++++++++++++
 tb/tb_note_sequencer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the step sequencer: step-word field positions,
// FSM states and the equal-temperament note period table.
package note_sequencer_pkg;

  localparam int         NOTE_MSB  = 5;
  localparam int         REST_BIT  = 6;
  localparam int         TIE_BIT   = 7;
  localparam logic [7:0] REST_WORD = 8'h40;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATE,
    S_HOLD,
    S_RETRIG
  } state_t;

  // Periods in 40 kHz samples for C2..B2, scaled by 32 so the octave shift can round.
  function automatic logic [31:0] note_period(input logic [5:0] note);
    logic [15:0] base;
    logic [3:0]  oct;
    logic [3:0]  semi;
    logic [31:0] scaled;
    oct  = 4'(note / 6'd12);
    semi = 4'(note % 6'd12);
    case (semi)
      4'd0:    base = 16'd19570;
      4'd1:    base = 16'd18472;
      4'd2:    base = 16'd17435;
      4'd3:    base = 16'd16456;
      4'd4:    base = 16'd15533;
      4'd5:    base = 16'd14661;
      4'd6:    base = 16'd13838;
      4'd7:    base = 16'd13061;
      4'd8:    base = 16'd12328;
      4'd9:    base = 16'd11636;
      4'd10:   base = 16'd10983;
      default: base = 16'd10367;
    endcase
    scaled = 32'(base) + (32'd1 << (oct + 4'd4));
    return scaled >> (oct + 4'd5);
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control, pattern-write and voice-output signals of the step sequencer.
interface note_sequencer_if #(
  parameter int STEPS = 16,
  parameter int TW    = 24
);
  localparam int IW = $clog2(STEPS);

  logic          start;
  logic          stop;
  logic [IW-1:0] loop_last;
  logic [TW-1:0] step_len;
  logic [TW-1:0] gate_len;
  logic          pat_we;
  logic [IW-1:0] pat_addr;
  logic [7:0]    pat_wdata;
  logic          trig;
  logic [31:0]   osc_count;
  logic [IW-1:0] step_idx;
  logic          busy;

  modport master (
    output start, stop, loop_last, step_len, gate_len, pat_we, pat_addr, pat_wdata,
    input  trig, osc_count, step_idx, busy
  );

  modport slave (
    input  start, stop, loop_last, step_len, gate_len, pat_we, pat_addr, pat_wdata,
    output trig, osc_count, step_idx, busy
  );
endinterface

// File: rtl/note_sequencer_rom.sv
// Combinational note number to oscillator period lookup used at step load.
module note_period_rom
  import note_sequencer_pkg::*;
(
  input  logic [5:0]  note_i,
  output logic [31:0] period_o
);
  assign period_o = note_period(note_i);
endmodule

// File: rtl/note_sequencer.sv
// Step sequencer: walks a pattern RAM, driving gate level and oscillator
// period for the synth voice with per-step gate/hold timing.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int          STEPS      = 16,
  parameter int          TW         = 24,
  parameter logic [31:0] IDLE_COUNT = 32'd512
) (
  input logic              clk,
  input logic              rst,
  note_sequencer_if.slave  bus
);
  localparam int IW = $clog2(STEPS);

  logic [7:0] pat_words [STEPS];

  genvar gi;
  generate
    for (gi = 0; gi < STEPS; gi++) begin : g_pat
      logic [7:0] word_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          word_q <= REST_WORD;
        end else if (bus.pat_we && bus.pat_addr == IW'(gi)) begin
          word_q <= bus.pat_wdata;
        end
      end
      assign pat_words[gi] = word_q;
    end
  endgenerate

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          tie_q, tie_d;
  logic          trig_q, trig_d;
  logic          busy_q, busy_d;
  logic [31:0]   osc_q, osc_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [TW-1:0] step_eff, gate_eff;
  logic [IW-1:0] next_idx, load_idx;
  logic [7:0]    load_word;
  logic [31:0]   load_period;
  logic          do_load;

  // Clamp so every non-tied step keeps at least one cycle of gate low.
  always_comb begin
    step_eff = (bus.step_len < TW'(2)) ? TW'(2) : bus.step_len;
    gate_eff = (bus.gate_len == '0) ? TW'(1) : bus.gate_len;
    if (gate_eff > step_eff - TW'(1)) gate_eff = step_eff - TW'(1);
  end

  assign next_idx  = (idx_q >= bus.loop_last) ? '0 : idx_q + IW'(1);
  assign load_idx  = (bus.start || state_q != S_HOLD) ? '0 : next_idx;
  assign load_word = pat_words[load_idx];

  note_period_rom u_rom (
    .note_i   (load_word[NOTE_MSB:0]),
    .period_o (load_period)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tie_d   = tie_q;
    trig_d  = trig_q;
    busy_d  = busy_q;
    osc_d   = osc_q;
    idx_d   = idx_q;
    do_load = 1'b0;

    if (bus.stop) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      trig_d  = 1'b0;
      busy_d  = 1'b0;
      osc_d   = IDLE_COUNT;
      idx_d   = '0;
    end else if (bus.start && trig_q) begin
      // Drop the gate for one cycle so the synth sees a fresh rising edge.
      state_d = S_RETRIG;
      cnt_d   = '0;
      trig_d  = 1'b0;
    end else if (bus.start || state_q == S_RETRIG) begin
      do_load = 1'b1;
    end else begin
      case (state_q)
        S_GATE: begin
          cnt_d = cnt_q + TW'(1);
          if (cnt_q >= gate_eff - TW'(1)) begin
            state_d = S_HOLD;
            trig_d  = tie_q;
          end
        end
        S_HOLD: begin
          if (cnt_q >= step_eff - TW'(1)) do_load = 1'b1;
          else                            cnt_d   = cnt_q + TW'(1);
        end
        default: ;
      endcase
    end

    if (do_load) begin
      state_d = S_GATE;
      cnt_d   = '0;
      idx_d   = load_idx;
      busy_d  = 1'b1;
      tie_d   = load_word[TIE_BIT] & ~load_word[REST_BIT];
      trig_d  = ~load_word[REST_BIT];
      osc_d   = load_word[REST_BIT] ? IDLE_COUNT : load_period;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tie_q   <= 1'b0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      osc_q   <= IDLE_COUNT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tie_q   <= tie_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      osc_q   <= osc_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.trig      = trig_q;
  assign bus.busy      = busy_q;
  assign bus.osc_count = osc_q;
  assign bus.step_idx  = idx_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed table, corner sequences
// and randomized traffic against a step/position reference model.
module tb_note_sequencer;
  localparam int STEPS = 16;
  localparam int TW    = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  note_sequencer_if #(.STEPS(STEPS), .TW(TW)) bus ();

  note_sequencer #(.STEPS(STEPS), .TW(TW), .IDLE_COUNT(32'd512)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: playing flag, position within step, current word.
  bit          m_play, m_pend, m_trig;
  int          m_pos, m_idx;
  logic [31:0] m_osc;
  logic [7:0]  m_word;
  logic [7:0]  m_ram [STEPS];

  typedef struct {
    int sl;
    int gl;
    int hi;
    int lo;
  } vec_t;
  vec_t vecs [8];

  function automatic int ref_period(int n);
    real f;
    f = 65.406391 * (2.0 ** (real'(n) / 12.0));
    return $rtoi(40000.0 / f + 0.5);
  endfunction

  task automatic check(string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_osc(string name, input logic [31:0] act, input logic [31:0] exp);
    int d;
    checks++;
    d = int'(act) - int'(exp);
    if ($isunknown(act) || d > 1 || d < -1) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_play = 0; m_pend = 0; m_trig = 0; m_pos = 0; m_idx = 0;
    m_osc = 32'd512; m_word = 8'h40;
    foreach (m_ram[i]) m_ram[i] = 8'h40;
  endtask

  task automatic m_load(int i);
    m_word = m_ram[i];
    m_idx  = i;
    m_pos  = 0;
    m_play = 1;
    m_pend = 0;
    m_trig = !m_word[6];
    m_osc  = m_word[6] ? 32'd512 : 32'(ref_period(int'(m_word[5:0])));
  endtask

  task automatic m_step();
    int s, g;
    s = (bus.step_len < 2) ? 2 : int'(bus.step_len);
    g = (bus.gate_len < 1) ? 1 : int'(bus.gate_len);
    if (g > s - 1) g = s - 1;
    if (bus.stop) begin
      m_play = 0; m_pend = 0; m_trig = 0; m_osc = 32'd512; m_idx = 0;
    end else if (bus.start) begin
      if (m_trig) begin
        m_pend = 1;
        m_trig = 0;
      end else begin
        m_load(0);
      end
    end else if (m_pend) begin
      m_load(0);
    end else if (m_play) begin
      m_pos++;
      if (m_pos >= s) m_load((m_idx >= int'(bus.loop_last)) ? 0 : m_idx + 1);
      else m_trig = !m_word[6] && (m_pos < g || m_word[7]);
    end
    if (bus.pat_we) m_ram[bus.pat_addr] = bus.pat_wdata;
  endtask

  task automatic cycle();
    @(posedge clk);
    m_step();
    @(negedge clk);
    check("trig", bus.trig, m_trig);
    check("busy", bus.busy, m_play);
    check("step_idx", bus.step_idx, m_idx);
    check_osc("osc_count", bus.osc_count, m_osc);
    bus.start  = 0;
    bus.stop   = 0;
    bus.pat_we = 0;
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic write(int a, logic [7:0] d);
    bus.pat_we    = 1;
    bus.pat_addr  = 4'(a);
    bus.pat_wdata = d;
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, lo, n, r;
    vecs[0] = '{sl: 10, gl: 4,  hi: 4, lo: 6};
    vecs[1] = '{sl: 10, gl: 20, hi: 9, lo: 1};
    vecs[2] = '{sl: 0,  gl: 5,  hi: 1, lo: 1};
    vecs[3] = '{sl: 1,  gl: 0,  hi: 1, lo: 1};
    vecs[4] = '{sl: 6,  gl: 0,  hi: 1, lo: 5};
    vecs[5] = '{sl: 7,  gl: 6,  hi: 6, lo: 1};
    vecs[6] = '{sl: 2,  gl: 1,  hi: 1, lo: 1};
    vecs[7] = '{sl: 3,  gl: 9,  hi: 2, lo: 1};

    bus.start = 0; bus.stop = 0; bus.pat_we = 0; bus.pat_addr = '0; bus.pat_wdata = '0;
    bus.loop_last = '0; bus.step_len = 24'd4; bus.gate_len = 24'd2;
    m_reset();
    repeat (2) @(negedge clk);
    check("rst_trig", bus.trig, 0);
    check("rst_osc", bus.osc_count, 512);
    check("rst_busy", bus.busy, 0);
    check("rst_idx", bus.step_idx, 0);
    rst = 0;

    // Cleared pattern plays as rests.
    bus.loop_last = 4'd1; bus.start = 1; cycle();
    check("rest_trig", bus.trig, 0);
    check("rest_osc", bus.osc_count, 512);
    check("rest_busy", bus.busy, 1);
    bus.stop = 1; cycle();
    $display("seq reset/rest done");

    // Basic loop: notes 0..3, 10-cycle steps, 4-cycle gate.
    for (int i = 0; i < 4; i++) write(i, 8'(i));
    bus.loop_last = 4'd3; bus.step_len = 24'd10; bus.gate_len = 24'd4;
    bus.start = 1; cycle();
    for (int st = 0; st < 5; st++) begin
      check("loop_idx", bus.step_idx, st % 4);
      check_osc("loop_osc", bus.osc_count, 32'(ref_period(st % 4)));
      hi = 0;
      for (int c = 0; c < 10; c++) begin
        if (bus.trig) hi++;
        cycle();
      end
      check("loop_high", hi, 4);
      $display("loop step %0d high %0d", st, hi);
    end
    bus.stop = 1; cycle();

    // Gate/step clamping table.
    bus.loop_last = 4'd1;
    foreach (vecs[v]) begin
      bus.step_len = 24'(vecs[v].sl); bus.gate_len = 24'(vecs[v].gl);
      bus.start = 1; cycle();
      hi = 0; lo = 0; n = 0;
      while (bus.trig && n < 100) begin hi++; n++; cycle(); end
      while (!bus.trig && n < 100) begin lo++; n++; cycle(); end
      check("vec_high", hi, vecs[v].hi);
      check("vec_low", lo, vecs[v].lo);
      $display("vec %0d step_len %0d gate_len %0d high %0d low %0d", v, vecs[v].sl, vecs[v].gl, hi, lo);
      bus.stop = 1; cycle();
    end

    // Tie into a rest step.
    write(1, 8'h85); write(2, 8'h40);
    bus.loop_last = 4'd3; bus.step_len = 24'd6; bus.gate_len = 24'd2;
    bus.start = 1; cycle();
    run(6);
    check("tie_idx", bus.step_idx, 1);
    check("tie_trig_start", bus.trig, 1);
    run(5);
    check("tie_trig_end", bus.trig, 1);
    cycle();
    check("tie_rest_idx", bus.step_idx, 2);
    check("tie_rest_trig", bus.trig, 0);
    check("tie_rest_osc", bus.osc_count, 512);
    bus.stop = 1; cycle();
    $display("seq tie/rest done");

    // Control races.
    bus.start = 1; bus.stop = 1; cycle();
    check("race_busy", bus.busy, 0);
    bus.start = 1; cycle();
    cycle();
    bus.start = 1; cycle();
    check("retrig_low", bus.trig, 0);
    check("retrig_busy", bus.busy, 1);
    cycle();
    check("retrig_high", bus.trig, 1);
    check("retrig_idx", bus.step_idx, 0);
    bus.stop = 1; cycle();
    check("stop_busy", bus.busy, 0);
    $display("seq races done");

    // Live write to the playing step.
    write(2, 8'd7);
    bus.start = 1; cycle();
    run(12);
    check("live_idx", bus.step_idx, 2);
    check_osc("live_osc_old", bus.osc_count, 32'(ref_period(7)));
    write(2, 8'd20);
    check_osc("live_osc_keep", bus.osc_count, 32'(ref_period(7)));
    run(23);
    check("live_idx2", bus.step_idx, 2);
    check_osc("live_osc_new", bus.osc_count, 32'(ref_period(20)));
    $display("seq live write done");

    // Asynchronous reset mid-play.
    run(3);
    #2 rst = 1;
    #1;
    check("arst_trig", bus.trig, 0);
    check("arst_osc", bus.osc_count, 512);
    check("arst_busy", bus.busy, 0);
    check("arst_idx", bus.step_idx, 0);
    m_reset();
    @(negedge clk);
    rst = 0;
    $display("seq async reset done");

    // Randomized traffic.
    for (int k = 0; k < 4000; k++) begin
      r = int'($urandom_range(0, 255));
      if (r < 4) bus.start = 1;
      if (r >= 250) begin
        bus.stop     = 1;
        bus.step_len = 24'($urandom_range(0, 12));
        bus.gate_len = 24'($urandom_range(0, 14));
      end
      if ($urandom_range(0, 7) == 0) begin
        bus.pat_we    = 1;
        bus.pat_addr  = 4'($urandom_range(0, STEPS - 1));
        bus.pat_wdata = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 49) == 0) bus.loop_last = 4'($urandom_range(0, STEPS - 1));
      cycle();
    end
    $display("seq random done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
